// File: rtl/core_pkg.sv
// Shared decode definitions: RV opcode constants, instruction format enum
// and the packed field bundle passed from the field decoder to the pipeline.
package core_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ILLEGAL = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [6:0] funct7;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        fmt_e       fmt;
        logic       illegal;
    } dec_fields_t;

    // Only base ADD/SUB-style funct7 encodings are supported for R-type.
    function automatic logic funct7_ok(input logic [6:0] f7);
        return (f7 == 7'b0000000) || (f7 == 7'b0100000);
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational RV32/RV64 base instruction field extraction and
// immediate generation; unused fields are forced to zero per format.
module instr_field_decode
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output dec_fields_t     fields,
    output logic [XLEN-1:0] imm
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]      opc_s;
    logic            r_f7_ok_s;
    fmt_e            fmt_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_s_s;
    logic [XLEN-1:0] imm_b_s;
    logic [XLEN-1:0] imm_u_s;
    logic [XLEN-1:0] imm_j_s;

    assign opc_s     = instr[6:0];
    assign r_f7_ok_s = funct7_ok(instr[31:25]);

    // Size casts of signed operands replicate instr[31] up to XLEN.
    assign imm_i_s = XLEN'($signed(instr[31:20]));
    assign imm_s_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b_s = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u_s = XLEN'($signed({instr[31:12], 12'h000}));
    assign imm_j_s = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    // Classify the opcode into a format; anything unlisted is illegal.
    always_comb begin
        fmt_s = FMT_ILLEGAL;
        case (opc_s)
            OPC_OP:        fmt_s = r_f7_ok_s ? FMT_R : FMT_ILLEGAL;
            OPC_OP_32:     fmt_s = (RV64 && r_f7_ok_s) ? FMT_R : FMT_ILLEGAL;
            OPC_OP_IMM:    fmt_s = FMT_I;
            OPC_OP_IMM_32: fmt_s = RV64 ? FMT_I : FMT_ILLEGAL;
            OPC_LOAD:      fmt_s = FMT_I;
            OPC_JALR:      fmt_s = FMT_I;
            OPC_MISC_MEM:  fmt_s = FMT_I;
            OPC_SYSTEM:    fmt_s = FMT_I;
            OPC_STORE:     fmt_s = FMT_S;
            OPC_BRANCH:    fmt_s = FMT_B;
            OPC_LUI:       fmt_s = FMT_U;
            OPC_AUIPC:     fmt_s = FMT_U;
            OPC_JAL:       fmt_s = FMT_J;
            default:       fmt_s = FMT_ILLEGAL;
        endcase
    end

    // Route only the fields each format actually uses.
    always_comb begin
        fields         = '0;
        imm            = '0;
        fields.fmt     = fmt_s;
        fields.illegal = (fmt_s == FMT_ILLEGAL);
        case (fmt_s)
            FMT_R: begin
                fields.opcode = opc_s;
                fields.funct7 = instr[31:25];
                fields.funct3 = instr[14:12];
                fields.rs1    = instr[19:15];
                fields.rs2    = instr[24:20];
                fields.rd     = instr[11:7];
            end
            FMT_I: begin
                fields.opcode = opc_s;
                fields.funct7 = instr[31:25];
                fields.funct3 = instr[14:12];
                fields.rs1    = instr[19:15];
                fields.rd     = instr[11:7];
                imm           = imm_i_s;
            end
            FMT_S: begin
                fields.opcode = opc_s;
                fields.funct3 = instr[14:12];
                fields.rs1    = instr[19:15];
                fields.rs2    = instr[24:20];
                imm           = imm_s_s;
            end
            FMT_B: begin
                fields.opcode = opc_s;
                fields.funct3 = instr[14:12];
                fields.rs1    = instr[19:15];
                fields.rs2    = instr[24:20];
                imm           = imm_b_s;
            end
            FMT_U: begin
                fields.opcode = opc_s;
                fields.rd     = instr[11:7];
                imm           = imm_u_s;
            end
            FMT_J: begin
                fields.opcode = opc_s;
                fields.rd     = instr[11:7];
                imm           = imm_j_s;
            end
            default: begin
                fields.fmt     = FMT_ILLEGAL;
                fields.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: field decode followed by a valid/ready output
// register, optionally backed by a skid entry so o_ready can be registered.
module decode_stage
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [6:0]      o_opcode,
    output logic [6:0]      o_funct7,
    output logic [2:0]      o_funct3,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt,
    output logic            o_illegal
);

    dec_fields_t     dec_fields_s;
    logic [XLEN-1:0] dec_imm_s;

    logic            out_valid_r;
    dec_fields_t     out_fields_r;
    logic [XLEN-1:0] out_pc_r;
    logic [XLEN-1:0] out_imm_r;

    logic            skid_valid_r;
    dec_fields_t     skid_fields_r;
    logic [XLEN-1:0] skid_pc_r;
    logic [XLEN-1:0] skid_imm_r;

    logic            ready_r;
    logic            ready_n;
    logic            out_valid_n;
    logic            skid_valid_n;
    logic            out_load_s;
    logic            out_from_skid_s;
    logic            skid_load_s;
    logic            accept_s;
    logic            fire_s;

    instr_field_decode #(
        .XLEN (XLEN)
    ) u_field_decode (
        .instr  (i_instr),
        .fields (dec_fields_s),
        .imm    (dec_imm_s)
    );

    // Without a skid entry ready_r only masks o_ready until reset has been released.
    assign o_ready  = SKID_EN ? ready_r : (ready_r && (!out_valid_r || i_ready));
    assign accept_s = i_valid && o_ready;
    assign fire_s   = out_valid_r && i_ready;
    assign ready_n  = SKID_EN ? !skid_valid_n : 1'b1;

    // Next-state for the output and skid slots; flush overrides any transfer.
    always_comb begin
        out_valid_n     = out_valid_r;
        skid_valid_n    = skid_valid_r;
        out_load_s      = 1'b0;
        out_from_skid_s = 1'b0;
        skid_load_s     = 1'b0;
        if (i_flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else if (SKID_EN) begin
            if (!out_valid_r || fire_s) begin
                if (skid_valid_r) begin
                    out_from_skid_s = 1'b1;
                    out_valid_n     = 1'b1;
                    skid_valid_n    = 1'b0;
                end else if (accept_s) begin
                    out_load_s  = 1'b1;
                    out_valid_n = 1'b1;
                end else begin
                    out_valid_n = 1'b0;
                end
            end else if (accept_s) begin
                skid_load_s  = 1'b1;
                skid_valid_n = 1'b1;
            end else begin
                skid_valid_n = skid_valid_r;
            end
        end else begin
            if (accept_s) begin
                out_load_s  = 1'b1;
                out_valid_n = 1'b1;
            end else if (fire_s) begin
                out_valid_n = 1'b0;
            end else begin
                out_valid_n = out_valid_r;
            end
        end
    end

    // Control and payload registers; reset discards anything held.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_r   <= 1'b0;
            skid_valid_r  <= 1'b0;
            ready_r       <= 1'b0;
            out_fields_r  <= '0;
            out_pc_r      <= '0;
            out_imm_r     <= '0;
            skid_fields_r <= '0;
            skid_pc_r     <= '0;
            skid_imm_r    <= '0;
        end else begin
            out_valid_r  <= out_valid_n;
            skid_valid_r <= skid_valid_n;
            ready_r      <= ready_n;
            if (out_from_skid_s) begin
                out_fields_r <= skid_fields_r;
                out_pc_r     <= skid_pc_r;
                out_imm_r    <= skid_imm_r;
            end else if (out_load_s) begin
                out_fields_r <= dec_fields_s;
                out_pc_r     <= i_pc;
                out_imm_r    <= dec_imm_s;
            end
            if (skid_load_s) begin
                skid_fields_r <= dec_fields_s;
                skid_pc_r     <= i_pc;
                skid_imm_r    <= dec_imm_s;
            end
        end
    end

    assign o_valid   = out_valid_r;
    assign o_pc      = out_pc_r;
    assign o_opcode  = out_fields_r.opcode;
    assign o_funct7  = out_fields_r.funct7;
    assign o_funct3  = out_fields_r.funct3;
    assign o_rs1     = out_fields_r.rs1;
    assign o_rs2     = out_fields_r.rs2;
    assign o_rd      = out_fields_r.rd;
    assign o_imm     = out_imm_r;
    assign o_fmt     = out_fields_r.fmt;
    assign o_illegal = out_fields_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV32 skid instance and an RV64
// single-register instance driven from a hand-computed vector table.
module tb_decode_stage;

    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4, F_J = 3'd5, F_X = 3'd6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        v32 = 1'b0, v64 = 1'b0, i_ready = 1'b1, i_flush = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [63:0] pc = 64'h0;

    logic        r32, ov32, ill32;
    logic [31:0] pc32o, imm32;
    logic [6:0]  opc32, f7_32;
    logic [2:0]  f3_32, fmt32;
    logic [4:0]  rs1_32, rs2_32, rd_32;

    logic        r64, ov64, ill64;
    logic [63:0] pc64o, imm64;
    logic [6:0]  opc64, f7_64;
    logic [2:0]  f3_64, fmt64;
    logic [4:0]  rs1_64, rs2_64, rd_64;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .SKID_EN(1'b1)) d32 (
        .clk(clk), .rstn(rstn), .i_valid(v32), .o_ready(r32), .i_instr(instr),
        .i_pc(pc[31:0]), .i_flush(i_flush), .o_valid(ov32), .i_ready(i_ready),
        .o_pc(pc32o), .o_opcode(opc32), .o_funct7(f7_32), .o_funct3(f3_32),
        .o_rs1(rs1_32), .o_rs2(rs2_32), .o_rd(rd_32), .o_imm(imm32),
        .o_fmt(fmt32), .o_illegal(ill32)
    );

    decode_stage #(.XLEN(64), .SKID_EN(1'b0)) d64 (
        .clk(clk), .rstn(rstn), .i_valid(v64), .o_ready(r64), .i_instr(instr),
        .i_pc(pc), .i_flush(i_flush), .o_valid(ov64), .i_ready(i_ready),
        .o_pc(pc64o), .o_opcode(opc64), .o_funct7(f7_64), .o_funct3(f3_64),
        .o_rs1(rs1_64), .o_rs2(rs2_64), .o_rd(rd_64), .o_imm(imm64),
        .o_fmt(fmt64), .o_illegal(ill64)
    );

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  fmt;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        ill32;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pk(input logic [6:0] opc, input logic [6:0] f7,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rd,
                                        input logic [2:0] fmt, input logic ill,
                                        input logic [63:0] imm);
        return {28'h0, opc, f7, f3, rs1, rs2, rd, fmt, ill, imm};
    endfunction

    function automatic logic [127:0] act32();
        return pk(opc32, f7_32, f3_32, rs1_32, rs2_32, rd_32, fmt32, ill32, {32'h0, imm32});
    endfunction

    function automatic logic [127:0] act64();
        return pk(opc64, f7_64, f3_64, rs1_64, rs2_64, rd_64, fmt64, ill64, imm64);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] e32, e64, illv;
        logic [63:0]  pcv;
        logic [31:0]  pa[4];
        logic [31:0]  qi[4];
        logic [31:0]  emitted[4];
        int           idx, nemit, first_low;

        vecs[0]  = '{32'hFFF10093, F_I, 7'h13, 7'h7F, 3'd0, 5'd2,  5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[1]  = '{32'hFE000EE3, F_B, 7'h63, 7'h00, 3'd0, 5'd0,  5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[2]  = '{32'h00000000, F_X, 7'h00, 7'h00, 3'd0, 5'd0,  5'd0, 5'd0, 64'h0, 1'b1};
        vecs[3]  = '{32'h002081B3, F_R, 7'h33, 7'h00, 3'd0, 5'd1,  5'd2, 5'd3, 64'h0, 1'b0};
        vecs[4]  = '{32'h407302B3, F_R, 7'h33, 7'h20, 3'd0, 5'd6,  5'd7, 5'd5, 64'h0, 1'b0};
        vecs[5]  = '{32'h022081B3, F_X, 7'h00, 7'h00, 3'd0, 5'd0,  5'd0, 5'd0, 64'h0, 1'b1};
        vecs[6]  = '{32'hFE552E23, F_S, 7'h23, 7'h00, 3'd2, 5'd10, 5'd5, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[7]  = '{32'h800003B7, F_U, 7'h37, 7'h00, 3'd0, 5'd0,  5'd0, 5'd7, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[8]  = '{32'h12345097, F_U, 7'h17, 7'h00, 3'd0, 5'd0,  5'd0, 5'd1, 64'h0000_0000_1234_5000, 1'b0};
        vecs[9]  = '{32'hFF9FF0EF, F_J, 7'h6F, 7'h00, 3'd0, 5'd0,  5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        vecs[10] = '{32'h00008067, F_I, 7'h67, 7'h00, 3'd0, 5'd1,  5'd0, 5'd0, 64'h0, 1'b0};
        vecs[11] = '{32'h7FF12303, F_I, 7'h03, 7'h3F, 3'd2, 5'd2,  5'd0, 5'd6, 64'h7FF, 1'b0};
        vecs[12] = '{32'hFFF1009B, F_I, 7'h1B, 7'h7F, 3'd0, 5'd2,  5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[13] = '{32'h002081BB, F_R, 7'h3B, 7'h00, 3'd0, 5'd1,  5'd2, 5'd3, 64'h0, 1'b1};
        vecs[14] = '{32'h00004501, F_X, 7'h00, 7'h00, 3'd0, 5'd0,  5'd0, 5'd0, 64'h0, 1'b1};
        vecs[15] = '{32'h0000007F, F_X, 7'h00, 7'h00, 3'd0, 5'd0,  5'd0, 5'd0, 64'h0, 1'b1};
        vecs[16] = '{32'h00000073, F_I, 7'h73, 7'h00, 3'd0, 5'd0,  5'd0, 5'd0, 64'h0, 1'b0};
        vecs[17] = '{32'h0FF0000F, F_I, 7'h0F, 7'h07, 3'd0, 5'd0,  5'd0, 5'd0, 64'h0FF, 1'b0};
        illv = pk(7'h0, 7'h0, 3'd0, 5'd0, 5'd0, 5'd0, F_X, 1'b1, 64'h0);

        // Reset: inputs active must not be captured; everything reads zero.
        v32 = 1'b1; v64 = 1'b1; instr = 32'hFFF10093; pc = 64'h1234;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid32", ov32, 1'b0);
        check("rst_valid64", ov64, 1'b0);
        check("rst_ready32", r32, 1'b0);
        check("rst_ready64", r64, 1'b0);
        check("rst_payload32", {pc32o, act32()}, 0);
        check("rst_payload64", {pc64o, act64()}, 0);
        rstn = 1'b1; v32 = 1'b0; v64 = 1'b0;
        @(negedge clk);
        check("post_rst_ready32", r32, 1'b1);
        check("post_rst_ready64", r64, 1'b1);
        check("post_rst_valid32", ov32, 1'b0);

        // Table: one instruction per two cycles into both instances.
        for (int k = 0; k < NV; k++) begin
            pcv = 64'h0000_0001_0000_1000 + {k[61:0], 2'b00};
            @(negedge clk);
            v32 = 1'b1; v64 = 1'b1; instr = vecs[k].ins; pc = pcv;
            @(negedge clk);
            v32 = 1'b0; v64 = 1'b0;
            e64 = pk(vecs[k].opc, vecs[k].f7, vecs[k].f3, vecs[k].rs1, vecs[k].rs2,
                     vecs[k].rd, vecs[k].fmt, (vecs[k].fmt == F_X), vecs[k].imm);
            e32 = vecs[k].ill32 ? illv :
                  pk(vecs[k].opc, vecs[k].f7, vecs[k].f3, vecs[k].rs1, vecs[k].rs2,
                     vecs[k].rd, vecs[k].fmt, 1'b0, {32'h0, vecs[k].imm[31:0]});
            check($sformatf("vec%0d_valid", k), {ov32, ov64}, 2'b11);
            check($sformatf("vec%0d_dec32", k), act32(), e32);
            check($sformatf("vec%0d_dec64", k), act64(), e64);
            check($sformatf("vec%0d_pc", k), {pc64o, pc32o}, {pcv, pcv[31:0]});
        end
        @(negedge clk);
        check("table_drain", {ov32, ov64}, 2'b00);

        // Skid: four back-to-back, execute stalled for three cycles.
        pa[0] = 32'h200; pa[1] = 32'h204; pa[2] = 32'h208; pa[3] = 32'h20C;
        qi[0] = 32'hFFF10093; qi[1] = 32'h002081B3; qi[2] = 32'h407302B3; qi[3] = 32'h800003B7;
        idx = 0; nemit = 0; first_low = -1;
        for (int cyc = 0; cyc < 30 && nemit < 4; cyc++) begin
            @(negedge clk);
            i_ready = (cyc >= 3);
            if (cyc > 0 && cyc < 3) check($sformatf("stall_hold_c%0d", cyc), {ov32, pc32o}, {1'b1, pa[0]});
            if (!r32 && first_low < 0) first_low = idx;
            if (ov32 && i_ready) begin
                if (nemit < 4) emitted[nemit] = pc32o;
                nemit++;
            end
            if (idx < 4) begin
                v32 = 1'b1; instr = qi[idx]; pc = {32'h0, pa[idx]};
                if (r32) idx++;
            end else begin
                v32 = 1'b0;
            end
        end
        v32 = 1'b0;
        check("skid_ready_fall_after", first_low, 2);
        check("skid_emit_count", nemit, 4);
        for (int k = 0; k < 4; k++) check($sformatf("skid_order%0d", k), emitted[k], pa[k]);

        // Flush with skid full and a same-cycle input.
        @(negedge clk);
        i_ready = 1'b0; v32 = 1'b1; instr = 32'hFFF10093; pc = 64'h300;
        @(negedge clk);
        instr = 32'h002081B3; pc = 64'h304;
        @(negedge clk);
        check("full_ready_low", {r32, ov32, pc32o}, {1'b0, 1'b1, 32'h300});
        i_flush = 1'b1; instr = 32'h407302B3; pc = 64'h308;
        @(negedge clk);
        i_flush = 1'b0; v32 = 1'b0;
        check("flush_clears", {ov32, r32}, 2'b01);
        // Flush while ready: the input in that cycle is dropped.
        i_flush = 1'b1; v32 = 1'b1; i_ready = 1'b1; pc = 64'h30C;
        @(negedge clk);
        i_flush = 1'b0; v32 = 1'b0;
        check("flush_drops_input", ov32, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("no_ghost%0d", k), ov32, 1'b0);
        end
        v32 = 1'b1; instr = 32'h00008067; pc = 64'h310;
        @(negedge clk);
        v32 = 1'b0;
        check("post_flush_flow", {ov32, pc32o, opc32}, {1'b1, 32'h310, 7'h67});

        // Reset while skid holds two entries.
        @(negedge clk);
        i_ready = 1'b0; v32 = 1'b1; pc = 64'h400;
        @(negedge clk);
        pc = 64'h404;
        @(negedge clk);
        v32 = 1'b0; rstn = 1'b0;
        @(negedge clk);
        check("midrst_state", {ov32, r32, pc32o}, 0);
        rstn = 1'b1; i_ready = 1'b1;
        @(negedge clk);
        check("midrst_release", {ov32, r32}, 2'b01);
        @(negedge clk);
        check("midrst_nothing_held", ov32, 1'b0);

        // Single-register instance: combinational ready and pass-through.
        i_ready = 1'b0; v64 = 1'b1; instr = 32'h800003B7; pc = 64'h500;
        @(negedge clk);
        v64 = 1'b0;
        check("d64_stall_ready", {ov64, r64}, 2'b10);
        check("d64_lui_imm", imm64, 64'hFFFF_FFFF_8000_0000);
        i_ready = 1'b1;
        #1;
        check("d64_comb_ready", r64, 1'b1);
        v64 = 1'b1; instr = 32'h12345097; pc = 64'h504;
        @(negedge clk);
        v64 = 1'b0;
        check("d64_simul_inout", {ov64, pc64o}, {1'b1, 64'h504});
        @(negedge clk);
        check("d64_drain", ov64, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 XLEN, 32, datapath/immediate width; legal values 32, 64.
REQ-002 SKID_EN, 1, 1 = two-entry skid buffer with registered o_ready; 0 = single output register with combinational o_ready.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 i_valid  input  1  fetch offers instruction.
REQ-006 o_ready  output  1  stage accepts instruction this cycle.
REQ-007 i_instr  input  32  raw instruction word.
REQ-008 i_pc  input  XLEN  instruction address.
REQ-009 i_flush  input  1  discard all held and incoming instructions.
REQ-010 o_valid  output  1  decoded instruction available.
REQ-011 i_ready  input  1  execute accepts decoded instruction.
REQ-012 o_pc  output  XLEN  address of decoded instruction.
REQ-013 o_opcode/o_funct7/o_funct3  output  7/7/3  instruction fields.
REQ-014 o_rs1/o_rs2/o_rd  output  5 each  register addresses.
REQ-015 o_imm  output  XLEN  sign-extended immediate.
REQ-016 o_fmt  output  3  format enum: R, I, S, B, U, J, ILLEGAL.
REQ-017 o_illegal  output  1  instruction unsupported.

Function
REQ-018 Formats SHALL be: R = OP, OP-32; I = OP-IMM, OP-IMM-32, LOAD, JALR, MISC-MEM, SYSTEM; S = STORE; B = BRANCH; U = LUI, AUIPC; J = JAL.
REQ-019 Fields a format does not use SHALL be driven zero; o_rd zero for S/B, o_rs2 zero for I/U/J, o_rs1 zero for U/J, o_funct7 nonzero only for R and I.
REQ-020 Immediates SHALL sign-extend from instr[31] to XLEN; B/J bit 0 zero; U = instr[31:12] concatenated with 12 zero bits, then sign-extended to XLEN.
REQ-021 o_illegal SHALL assert when instr[1:0] != 2'b11, opcode unlisted, R-type funct7 not 0000000/0100000, or OP-32/OP-IMM-32 with XLEN=32; o_fmt = ILLEGAL and all fields and o_imm zero; no simulation messages.
REQ-022 Transfer in SHALL occur on i_valid && o_ready, out on o_valid && i_ready; latency one cycle.
REQ-023 While o_valid && !i_ready, all output payload SHALL remain stable.
REQ-024 SKID_EN=0: o_ready = !o_valid || i_ready; simultaneous in/out allowed.
REQ-025 SKID_EN=1: o_ready = registered !skid_full; input arriving while output stalled SHALL fill skid; on output transfer, skid entry SHALL move to output the next cycle; order preserved, no loss, no duplication.
REQ-026 i_flush SHALL clear o_valid and skid the next cycle, drop the same-cycle input, and take priority over transfer.

Reset
REQ-027 While rstn low at a clock edge: o_valid = 0, skid empty, all payload outputs zero, o_ready = 0.
REQ-028 First cycle after rstn high: o_ready = 1.
REQ-029 Reset mid-transfer SHALL discard all held instructions.

Structure
REQ-030 Opcode constants and the fmt enum SHALL live in core_pkg.
REQ-031 Combinational field extraction SHALL be sub-module instr_field_decode (parameter XLEN), instantiated once ahead of the pipeline register.

Verification
REQ-032 0xFFF10093 (addi x1,x2,-1), XLEN=32 -> next cycle o_valid=1, fmt I, rs1=2, rd=1, imm=0xFFFFFFFF.
REQ-033 0xFE000EE3 (beq x0,x0,-4) -> fmt B, rd=0, imm=0xFFFFFFFC.
REQ-034 0x00000000 -> o_illegal=1, fmt ILLEGAL, all fields and imm zero.
REQ-035 SKID_EN=1, 4 back-to-back instructions, i_ready low 3 cycles -> o_ready falls after 2 accepted; all 4 emerge in order once i_ready high.
REQ-036 Skid full, i_flush pulsed with i_valid=1 -> o_valid=0 next cycle, flushed-cycle input never emitted, o_ready=1.
REQ-037 0xFFF1009B (addiw): XLEN=64 -> legal, imm=0xFFFFFFFFFFFFFFFF; XLEN=32 -> o_illegal=1.
